// File: rtl/hline_zbuff_ctrl.sv
// Horizontal-span z-buffer controller: per burst chunk it reads z, interpolates and
// depth-tests each pixel, then writes z (optional) and the framebuffer byte-enable burst.
module hline_zbuff_ctrl #(
    parameter int BURST_MAX = 256,
    parameter int Z_W       = 32,
    parameter int BL_W      = 9
) (
    input  logic            clk,
    input  logic            nreset,
    input  logic            start,
    input  logic [31:0]     fb_addr,
    input  logic [31:0]     zbuff_addr,
    input  logic [15:0]     x1,
    input  logic [15:0]     x2,
    input  logic [Z_W-1:0]  z0,
    input  logic [Z_W-1:0]  dz,
    input  logic [1:0]      zfunc,
    input  logic            zwrite_en,
    output logic            busy,
    output logic            done,
    output logic [16:0]     pass_cnt,
    output logic            rd_req,
    output logic            wr_req,
    output logic [31:0]     addr,
    output logic [BL_W-1:0] burst_len,
    output logic            wr_sel,
    input  logic            mem_ack,
    input  logic            mem_done,
    input  logic            zrd_empty,
    input  logic [Z_W-1:0]  zrd_data,
    output logic            zrd_pop,
    output logic            zwr_push,
    output logic [Z_W-1:0]  zwr_data,
    output logic            be_push,
    output logic            be_bit
);
    typedef enum logic [2:0] {IDLE, RD, INTERP, WR_Z, WR_FB, NEXT} state_t;

    localparam logic [16:0] BMAX = 17'(BURST_MAX);

    state_t          state, state_nxt;
    logic [31:0]     fb_base, zb_base;
    logic [16:0]     x_cur, remaining;
    logic [Z_W-1:0]  z_acc, dz_q;
    logic [1:0]      zfunc_q;
    logic            zwen_q;
    logic [BL_W-1:0] words_left;
    logic            chunk_pass;
    logic            acked;

    logic [BL_W-1:0] chunk;
    logic [16:0]     rem_after;
    logic [15:0]     x_lo, x_diff;
    logic [16:0]     span_len;
    logic [31:0]     x_byte;
    logic            pass, pop, last_pop, launch;

    // remaining is 17 bits so a full 0..65535 span (65536 pixels) fits
    always_comb begin
        chunk     = (remaining > BMAX) ? BL_W'(BURST_MAX) : BL_W'(remaining);
        rem_after = remaining - 17'(chunk);
        x_lo      = (x1 < x2) ? x1 : x2;
        x_diff    = (x1 < x2) ? (x2 - x1) : (x1 - x2);
        span_len  = {1'b0, x_diff} + 17'd1;
        x_byte    = {13'b0, x_cur, 2'b00};
        pop       = (state == INTERP) && !zrd_empty;
        last_pop  = pop && (words_left == BL_W'(1));
        launch    = (state == IDLE) && start && !done;
        busy      = (state != IDLE);
    end

    always_comb begin
        case (zfunc_q)
            2'b00:   pass = z_acc <  zrd_data;
            2'b01:   pass = z_acc <= zrd_data;
            2'b10:   pass = z_acc >  zrd_data;
            default: pass = 1'b1;
        endcase
    end

    always_comb begin
        state_nxt = state;
        rd_req    = 1'b0;
        wr_req    = 1'b0;
        wr_sel    = 1'b0;
        addr      = '0;
        burst_len = '0;
        zrd_pop   = 1'b0;
        zwr_push  = 1'b0;
        be_push   = 1'b0;
        zwr_data  = '0;
        be_bit    = 1'b0;
        case (state)
            IDLE: if (launch) state_nxt = RD;
            RD: begin
                rd_req    = 1'b1;
                addr      = zb_base + x_byte;
                burst_len = chunk;
                if (mem_ack) state_nxt = INTERP;
            end
            INTERP: begin
                zrd_pop  = pop;
                zwr_push = pop;
                be_push  = pop;
                if (pop) begin
                    zwr_data = pass ? z_acc : zrd_data;
                    be_bit   = pass;
                end
                if (last_pop) begin
                    if (!(chunk_pass || pass)) state_nxt = NEXT;
                    else if (zwen_q)           state_nxt = WR_Z;
                    else                       state_nxt = WR_FB;
                end
            end
            WR_Z: begin
                wr_req    = !acked;
                addr      = zb_base + x_byte;
                burst_len = chunk;
                if (mem_done) state_nxt = WR_FB;
            end
            WR_FB: begin
                wr_req    = !acked;
                wr_sel    = 1'b1;
                addr      = fb_base + x_byte;
                burst_len = chunk;
                if (mem_done) state_nxt = NEXT;
            end
            NEXT:    state_nxt = (rem_after == '0) ? IDLE : RD;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state      <= IDLE;
            done       <= 1'b0;
            pass_cnt   <= '0;
            fb_base    <= '0;
            zb_base    <= '0;
            x_cur      <= '0;
            remaining  <= '0;
            z_acc      <= '0;
            dz_q       <= '0;
            zfunc_q    <= '0;
            zwen_q     <= 1'b0;
            words_left <= '0;
            chunk_pass <= 1'b0;
            acked      <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= (state == NEXT) && (rem_after == '0);
            case (state)
                IDLE: if (launch) begin
                    fb_base   <= fb_addr;
                    zb_base   <= zbuff_addr;
                    x_cur     <= {1'b0, x_lo};
                    remaining <= span_len;
                    z_acc     <= z0;
                    dz_q      <= dz;
                    zfunc_q   <= zfunc;
                    zwen_q    <= zwrite_en;
                    pass_cnt  <= '0;
                end
                RD: if (mem_ack) begin
                    words_left <= chunk;
                    chunk_pass <= 1'b0;
                    acked      <= 1'b0;
                end
                INTERP: if (pop) begin
                    z_acc      <= z_acc + dz_q;
                    pass_cnt   <= pass_cnt + {16'b0, pass};
                    words_left <= words_left - BL_W'(1);
                    chunk_pass <= chunk_pass | pass;
                end
                // acked clears on mem_done so WR_FB starts with a fresh request
                WR_Z, WR_FB: begin
                    if (mem_done)     acked <= 1'b0;
                    else if (mem_ack) acked <= 1'b1;
                end
                NEXT: begin
                    x_cur     <= x_cur + 17'(chunk);
                    remaining <= rem_after;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_hline_zbuff_ctrl.sv
// Directed bench for hline_zbuff_ctrl: bench plays burst master and FIFOs,
// records every request and push, and compares against hand-computed results.
module tb_hline_zbuff_ctrl;
    localparam int BURST_MAX = 256;
    localparam int Z_W       = 32;
    localparam int BL_W      = 9;

    logic            clk = 1'b0;
    logic            nreset = 1'b0;
    logic            start = 1'b0;
    logic [31:0]     fb_addr = '0, zbuff_addr = '0;
    logic [15:0]     x1 = '0, x2 = '0;
    logic [Z_W-1:0]  z0 = '0, dz = '0;
    logic [1:0]      zfunc = '0;
    logic            zwrite_en = 1'b0;
    logic            busy, done;
    logic [16:0]     pass_cnt;
    logic            rd_req, wr_req, wr_sel;
    logic [31:0]     addr;
    logic [BL_W-1:0] burst_len;
    logic            mem_ack = 1'b0, mem_done = 1'b0;
    logic            zrd_empty = 1'b1;
    logic [Z_W-1:0]  zrd_data = '0;
    logic            zrd_pop, zwr_push, be_push, be_bit;
    logic [Z_W-1:0]  zwr_data;

    hline_zbuff_ctrl #(.BURST_MAX(BURST_MAX), .Z_W(Z_W), .BL_W(BL_W)) dut (
        .clk(clk), .nreset(nreset), .start(start),
        .fb_addr(fb_addr), .zbuff_addr(zbuff_addr), .x1(x1), .x2(x2),
        .z0(z0), .dz(dz), .zfunc(zfunc), .zwrite_en(zwrite_en),
        .busy(busy), .done(done), .pass_cnt(pass_cnt),
        .rd_req(rd_req), .wr_req(wr_req), .addr(addr), .burst_len(burst_len),
        .wr_sel(wr_sel), .mem_ack(mem_ack), .mem_done(mem_done),
        .zrd_empty(zrd_empty), .zrd_data(zrd_data), .zrd_pop(zrd_pop),
        .zwr_push(zwr_push), .zwr_data(zwr_data), .be_push(be_push), .be_bit(be_bit)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [31:0] words[$];
    logic [31:0] rd_addr_q[$], rd_len_q[$], wr_sel_q[$], wr_addr_q[$], wr_len_q[$];
    logic [31:0] zwr_q[$], be_q[$];
    int          done_cnt;

    localparam logic [31:0] ZB = 32'h1000_0000;
    localparam logic [31:0] FB = 32'h2000_0000;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_span(input logic [15:0] a, input logic [15:0] b, input logic [31:0] zs,
                            input logic [31:0] d, input logic [1:0] f, input logic zw);
        x1 = a; x2 = b; z0 = zs; dz = d; zfunc = f; zwrite_en = zw;
        fb_addr = FB; zbuff_addr = ZB;
    endtask

    // Launch a span, act as master/FIFO until done, then watch a short idle tail.
    task automatic run_span(input int max_cyc, input bit stall, input int busy_start_at,
                            input bit start_on_done);
        int cyc = 0;
        int req_age = 0;
        bit fin = 0;
        logic [31:0] held_addr = '0;
        rd_addr_q.delete(); rd_len_q.delete(); wr_sel_q.delete();
        wr_addr_q.delete(); wr_len_q.delete(); zwr_q.delete(); be_q.delete();
        done_cnt = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        // scramble the span inputs: the controller must use the latched copies
        x1 = 16'd0; x2 = 16'd1000; z0 = '1; dz = 32'd77; zfunc = ~zfunc; zwrite_en = ~zwrite_en;
        fb_addr = 32'hDEAD_0000; zbuff_addr = 32'hBEEF_0000;
        #1;
        chk("busy_after_start", busy, 1);
        chk("rd_latency", rd_req, 1);
        while (!fin && cyc < max_cyc) begin
            mem_ack = 1'b0; mem_done = 1'b0;
            zrd_empty = (words.size() == 0) || (stall && (cyc % 2 == 1));
            zrd_data  = (words.size() != 0) ? words[0] : '0;
            start = (cyc == busy_start_at);
            #1;
            if (rd_req || wr_req) begin
                if (req_age == 0) held_addr = addr;
                else begin
                    chk("req_addr_hold", addr, held_addr);
                    mem_ack = 1'b1;
                    if (rd_req) begin
                        rd_addr_q.push_back(addr); rd_len_q.push_back(32'(burst_len));
                    end else begin
                        mem_done = 1'b1;
                        wr_sel_q.push_back(32'(wr_sel)); wr_addr_q.push_back(addr);
                        wr_len_q.push_back(32'(burst_len));
                    end
                end
                req_age = (mem_ack) ? 0 : req_age + 1;
            end else req_age = 0;
            if (zrd_empty) chk("pop_when_empty", zrd_pop, 0);
            if (zrd_pop || zwr_push || be_push)
                chk("push_align", {zwr_push, be_push}, {zrd_pop, zrd_pop});
            if (zwr_push) zwr_q.push_back(zwr_data);
            if (be_push)  be_q.push_back(32'(be_bit));
            if (zrd_pop && words.size() != 0) void'(words.pop_front());
            if (done) begin
                done_cnt++;
                chk("busy_low_with_done", busy, 0);
                if (start_on_done) start = 1'b1;
                fin = 1;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk("span_finished", fin, 1);
        repeat (4) begin
            #1;
            chk("idle_tail", {busy, rd_req, wr_req, done}, 0);
            @(negedge clk);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        chk("reset_ctl", {busy, done, rd_req, wr_req, wr_sel, zrd_pop, zwr_push, be_push, be_bit}, 0);
        chk("reset_data", {pass_cnt, addr, burst_len}, 0);
        chk("reset_zwr", zwr_data, 0);
        nreset = 1'b1;

        // 1: basic LESS, with FIFO stalls and a start pulse while busy
        set_span(10, 13, 100, 1, 2'b00, 1'b1);
        words = '{200, 200, 101, 50};
        run_span(200, 1, 5, 0);
        chk("t1_rd_n", rd_addr_q.size(), 1);
        chk("t1_rd_addr", rd_addr_q[0], ZB + 40);
        chk("t1_rd_len", rd_len_q[0], 4);
        chk("t1_be", {be_q[0][0], be_q[1][0], be_q[2][0], be_q[3][0]}, 4'b1100);
        chk("t1_zwr0", zwr_q[0], 100);
        chk("t1_zwr1", zwr_q[1], 101);
        chk("t1_zwr2", zwr_q[2], 101);
        chk("t1_zwr3", zwr_q[3], 50);
        chk("t1_wr_n", wr_sel_q.size(), 2);
        chk("t1_wrz", {wr_sel_q[0], wr_addr_q[0], wr_len_q[0]}, {32'd0, ZB + 32'd40, 32'd4});
        chk("t1_wrfb", {wr_sel_q[1], wr_addr_q[1], wr_len_q[1]}, {32'd1, FB + 32'd40, 32'd4});
        chk("t1_pass", pass_cnt, 2);
        chk("t1_done", done_cnt, 1);

        // 2: two-chunk span, everything passes
        set_span(0, 299, 0, 1, 2'b00, 1'b1);
        words.delete();
        for (int i = 0; i < 300; i++) words.push_back(32'hFFFF_FFFF);
        run_span(2000, 0, -1, 0);
        chk("t2_rd_n", rd_addr_q.size(), 2);
        chk("t2_rd0", {rd_addr_q[0], rd_len_q[0]}, {ZB, 32'd256});
        chk("t2_rd1", {rd_addr_q[1], rd_len_q[1]}, {ZB + 32'd1024, 32'd44});
        chk("t2_wr_n", wr_sel_q.size(), 4);
        chk("t2_wrfb1", {wr_sel_q[3], wr_addr_q[3], wr_len_q[3]}, {32'd1, FB + 32'd1024, 32'd44});
        chk("t2_pass", pass_cnt, 300);

        // 3: reversed endpoints, ALWAYS writes interpolated z
        set_span(20, 17, 1, 2, 2'b11, 1'b1);
        words = '{0, 0, 0, 0};
        run_span(200, 0, -1, 0);
        chk("t3_rd", {rd_addr_q[0], rd_len_q[0]}, {ZB + 32'd68, 32'd4});
        chk("t3_zwr", {zwr_q[0], zwr_q[3]}, {32'd1, 32'd7});
        chk("t3_pass", pass_cnt, 4);

        // 4: fully occluded chunk skips both write bursts
        set_span(0, 2, 5, 0, 2'b10, 1'b1);
        words = '{9, 9, 9};
        run_span(200, 0, -1, 0);
        chk("t4_wr_n", wr_sel_q.size(), 0);
        chk("t4_be", {be_q[0][0], be_q[1][0], be_q[2][0]}, 3'b000);
        chk("t4_pass", pass_cnt, 0);
        chk("t4_done", done_cnt, 1);

        // 5: ALWAYS without z write; start coincident with done is ignored
        set_span(100, 107, 0, 0, 2'b11, 1'b0);
        words = '{1, 2, 3, 4, 5, 6, 7, 8};
        run_span(200, 0, -1, 1);
        chk("t5_wr_n", wr_sel_q.size(), 1);
        chk("t5_wrfb", {wr_sel_q[0], wr_addr_q[0], wr_len_q[0]}, {32'd1, FB + 32'd400, 32'd8});
        chk("t5_pass", pass_cnt, 8);

        // 6: LEQUAL with negative dz wrapping below zero
        set_span(5, 6, 0, 32'hFFFF_FFFF, 2'b01, 1'b1);
        words = '{0, 5};
        run_span(200, 0, -1, 0);
        chk("t6_rd", {rd_addr_q[0], rd_len_q[0]}, {ZB + 32'd20, 32'd2});
        chk("t6_zwr", {zwr_q[0], zwr_q[1]}, {32'd0, 32'd5});
        chk("t6_be", {be_q[0][0], be_q[1][0]}, 2'b10);
        chk("t6_pass", pass_cnt, 1);

        // 7: single pixel at x=65535 with address wrap
        set_span(16'hFFFF, 16'hFFFF, 10, 0, 2'b10, 1'b1);
        zbuff_addr = 32'hFFFF_0000; fb_addr = 32'hFFFF_FFF0;
        words = '{3};
        run_span(200, 0, -1, 0);
        chk("t7_rd", {rd_addr_q[0], rd_len_q[0]}, {32'h0002_FFFC, 32'd1});
        chk("t7_wrfb", wr_addr_q[1], 32'h0003_FFEC);
        chk("t7_pass", pass_cnt, 1);

        // 8: reset asserted mid-INTERP
        set_span(0, 7, 0, 0, 2'b11, 1'b1);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; mem_ack = 1'b1; zrd_empty = 1'b0; zrd_data = 32'd5;
        @(negedge clk); mem_ack = 1'b0;
        #1;
        chk("t8_popping", zrd_pop, 1);
        nreset = 1'b0;
        #1;
        chk("t8_rst_ctl", {busy, done, rd_req, wr_req, wr_sel, zrd_pop, zwr_push, be_push, be_bit}, 0);
        chk("t8_rst_data", {pass_cnt, addr, burst_len}, 0);
        @(negedge clk); nreset = 1'b1;
        @(negedge clk);
        #1;
        chk("t8_idle", {busy, rd_req, zrd_pop}, 0);
        zrd_empty = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/hline_zbuff_ctrl.md
# hline_zbuff_ctrl

Parametrised horizontal-span z-buffer controller for the hline_zbuff pcore. It rasterises one horizontal span of a single colour. Each burst chunk runs the same sequence: burst-read the z-buffer chunk, interpolate z per pixel, apply a selectable depth test, write back z, then write the framebuffer. It sits between the register/start logic and the AXI burst master and its FIFOs. Successor to the fixed-256 controller: configurable burst size and z format, inclusive span length, four depth functions, z-write disable, skip of writes for fully occluded chunks, and a pass counter.

## Interface
- BURST_MAX, 256: maximum pixels per burst; power of two, 2..256.
- Z_W, 32: z value width in bits, unsigned.
- BL_W, 9: burst_len width; must be ≥ clog2(BURST_MAX)+1.
- clk  in  1  clock; all logic is on the rising edge.
- nreset  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse that launches a span; ignored while busy.
- fb_addr, zbuff_addr  in  32 each  row base byte addresses; pixel x lives at base+4*x.
- x1, x2  in  16 each  span endpoints, inclusive, in either order.
- z0  in  Z_W  z at min(x1,x2).
- dz  in  Z_W  per-pixel z increment in two's complement; adds wrap modulo 2^Z_W.
- zfunc  in  2  depth test: 00 LESS, 01 LEQUAL, 10 GREATER, 11 ALWAYS.
- zwrite_en  in  1  when 0, the controller never writes the z-buffer.
- zfunc, zwrite_en, z0, dz, x1, x2 and both base addresses are sampled on start.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse when the span completes.
- pass_cnt  out  17  number of pixels that passed; held until the next start.
- rd_req, wr_req  out  1 each  burst requests.
- addr  out  32  burst start byte address.
- burst_len  out  BL_W  burst length in words.
- wr_sel  out  1  0 = z-write burst, 1 = framebuffer burst.
- mem_ack  in  1  the burst master accepted the request.
- mem_done  in  1  write burst complete; ignored outside the WR states.
- zrd_empty  in  1  z read FIFO empty flag.
- zrd_data  in  Z_W  z read FIFO head.
- zrd_pop  out  1  z read FIFO pop.
- zwr_push  out  1  z write FIFO push.
- zwr_data  out  Z_W  z write FIFO data.
- be_push  out  1  byte-enable FIFO push.
- be_bit  out  1  byte-enable FIFO data; 1 = pixel passed.

## Operation
- States: IDLE, RD, INTERP, WR_Z, WR_FB, NEXT.
- IDLE, on start:
  - latch x_lo = min(x1,x2).
  - latch remaining = |x2−x1|+1 (17 bits).
  - set z_acc = z0 and pass_cnt = 0.
  - go to RD.
- RD:
  - chunk = min(remaining, BURST_MAX).
  - assert rd_req with addr = zbuff_addr+4*x_cur and burst_len = chunk.
  - on mem_ack, go to INTERP.
- INTERP:
  - zrd_pop = zwr_push = be_push = !zrd_empty, a Mealy output in the same cycle.
  - pass = zfunc(z_acc, zrd_data), comparing z_acc against zrd_data.
  - be_bit = pass.
  - zwr_data = pass ? z_acc : zrd_data.
  - on each pop: z_acc += dz, pass_cnt += pass, word count decrements.
  - after chunk pops:
    - if no pixel in the chunk passed, go to NEXT.
    - else if zwrite_en = 1, go to WR_Z.
    - else go to WR_FB.
- WR_Z:
  - wr_req with wr_sel = 0, addr = zbuff_addr+4*x_cur, burst_len = chunk.
  - wr_req drops on mem_ack.
  - mem_done moves to WR_FB.
  - The burst master consumes zwr and be FIFOs.
- WR_FB:
  - same as WR_Z but wr_sel = 1 and addr = fb_addr+4*x_cur.
  - The master pops the be FIFO for the framebuffer burst.
  - When zwrite_en = 1, the master replays the be entries saved during WR_Z.
  - mem_done moves to NEXT.
- NEXT:
  - x_cur += chunk, remaining −= chunk.
  - if remaining = 0, go to IDLE with a done pulse.
  - else go to RD.
- Skipped chunks (no pixel passed) leave zwr/be entries in the FIFOs. The master discards these when it sees no wr_req before the next rd_req.

## Timing
- Reset values: all outputs 0, state IDLE, internal registers 0.
- Reset mid-span returns to IDLE immediately. FIFOs are not flushed by this block.
- Latency:
  - start to rd_req is 1 cycle.
  - INTERP throughput is 1 pixel per cycle while zrd_empty is 0.
  - NEXT lasts 1 cycle.
  - done asserts in the cycle state returns to IDLE.
  - busy falls in the same cycle as done.
- Request handshake:
  - rd_req/wr_req stay high, with addr and burst_len stable, until mem_ack is sampled high.
  - mem_ack and mem_done in the same cycle count as both events.
- Boundaries:
  - x1 = x2 gives a 1-pixel span.
  - x endpoints 0 and 65535 give remaining = 65536.
  - addr arithmetic wraps at 2^32.
  - start coincident with done is ignored.

## Test plan
- Basic LESS span:
  - stimulus: BURST_MAX=256, x1=10, x2=13, z0=100, dz=1, FIFO words 200, 200, 101, 50, zfunc LESS.
  - expect: rd addr zb+40, len 4; be 1,1,0,0; zwr 100, 101, 101, 50; WR_Z then WR_FB at fb+40; pass_cnt 2; one done pulse.
- Two-chunk span:
  - stimulus: x1=0, x2=299, all words pass.
  - expect: chunks of 256 and 44; second rd addr zb+1024; pass_cnt 300.
- Reversed endpoints:
  - stimulus: x1=20, x2=17.
  - expect: rd addr zb+68, burst_len 4.
- Fully occluded chunk:
  - stimulus: zfunc GREATER, z0=5, dz=0, words 9.
  - expect: no wr_req; done after INTERP and NEXT; pass_cnt 0.
- ALWAYS without z write:
  - stimulus: zfunc ALWAYS, zwrite_en=0, 8 pixels.
  - expect: only the WR_FB burst is issued (wr_sel=1); pass_cnt 8.
- Reset and busy behaviour:
  - nreset low mid-INTERP: all outputs 0 in the same cycle, FSM in IDLE.
  - start pulsed while busy: no effect on span or pass_cnt.
